// File: rtl/sdram_client_arbiter.sv
// Shares one SDRAM controller request port between NUM_CLIENTS requesters.
// Ports:
//   clock, reset          : controller clock, synchronous active-high reset
//   in_req_* / out_req_*  : per-client pulse-valid / pulse-done request side
//   out_sd_* / in_sd_*    : single request port towards the SDRAM controller
//   out_grant             : index of the client currently or last served
//   out_overrun           : sticky flag, a client re-requested while pending
module sdram_client_arbiter #(
  parameter int NUM_CLIENTS  = 2,
  parameter bit PRIO_CLIENT0 = 1'b1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [32*NUM_CLIENTS-1:0] in_req_addr,
  input  logic [NUM_CLIENTS-1:0]    in_req_rw,
  input  logic [32*NUM_CLIENTS-1:0] in_req_data,
  input  logic [NUM_CLIENTS-1:0]    in_req_wmask,
  input  logic [NUM_CLIENTS-1:0]    in_req_valid,
  output logic [NUM_CLIENTS-1:0]    out_req_done,
  output logic [31:0]               out_req_data,
  output logic [31:0]               out_sd_addr,
  output logic                      out_sd_rw,
  output logic [31:0]               out_sd_data_in,
  output logic                      out_sd_wmask,
  output logic                      out_sd_in_valid,
  input  logic [31:0]               in_sd_data_out,
  input  logic                      in_sd_done,
  output logic [1:0]                out_grant,
  output logic                      out_overrun
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t state, state_nx;

  logic [31:0] slot_addr [NUM_CLIENTS];
  logic [31:0] slot_data [NUM_CLIENTS];
  logic [NUM_CLIENTS-1:0] slot_rw;
  logic [NUM_CLIENTS-1:0] slot_wmask;
  logic [NUM_CLIENTS-1:0] pend;
  logic [NUM_CLIENTS-1:0] retire;
  logic [1:0] rr_ptr, rr_nx;
  logic [1:0] win;
  logic       win_ok;
  logic       fin;

  logic [31:0] sel_addr, sel_data;
  logic        sel_rw, sel_wmask;
  logic        load;
  logic [NUM_CLIENTS-1:0] done_nx;

  assign fin = (state == S_WAIT) && in_sd_done;

  always_comb begin
    retire = '0;
    for (int i = 0; i < NUM_CLIENTS; i++)
      retire[i] = fin && (out_grant == 2'(i));
  end

  always_comb begin
    rr_nx = 2'((int'(out_grant) + 1) % NUM_CLIENTS);
  end

  // Winner: client 0 overrides when prioritised, else first pending
  // slot at or after rr_ptr (client 0 excluded from the rotation).
  always_comb begin
    int idx;
    idx    = 0;
    win    = '0;
    win_ok = 1'b0;
    if (PRIO_CLIENT0 && pend[0]) begin
      win_ok = 1'b1;
    end else begin
      for (int k = 0; k < NUM_CLIENTS; k++) begin
        idx = (int'(rr_ptr) + k) % NUM_CLIENTS;
        if (!win_ok && pend[idx] && !(PRIO_CLIENT0 && idx == 0)) begin
          win    = 2'(idx);
          win_ok = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_data  = '0;
    sel_rw    = 1'b1;
    sel_wmask = 1'b0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (win == 2'(i)) begin
        sel_addr  = slot_addr[i];
        sel_data  = slot_data[i];
        sel_rw    = slot_rw[i];
        sel_wmask = slot_wmask[i];
      end
    end
  end

  // A retiring slot may be refilled in the same edge; the new set wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend        <= '0;
      out_overrun <= 1'b0;
      slot_rw     <= '0;
      slot_wmask  <= '0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        slot_addr[i] <= '0;
        slot_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        if (in_req_valid[i] && pend[i] && !retire[i]) begin
          out_overrun <= 1'b1;
        end else if (in_req_valid[i]) begin
          slot_addr[i]  <= in_req_addr[32*i +: 32];
          slot_data[i]  <= in_req_data[32*i +: 32];
          slot_rw[i]    <= in_req_rw[i];
          slot_wmask[i] <= in_req_wmask[i];
          pend[i]       <= 1'b1;
        end else if (retire[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_IDLE;
      rr_ptr <= '0;
    end else begin
      state <= state_nx;
      if (fin)
        rr_ptr <= rr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (win_ok) state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (in_sd_done) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    load    = (state == S_IDLE) && win_ok;
    done_nx = retire;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_sd_in_valid <= 1'b0;
      out_sd_addr     <= '0;
      out_sd_data_in  <= '0;
      out_sd_rw       <= 1'b1;
      out_sd_wmask    <= 1'b0;
      out_grant       <= '0;
      out_req_done    <= '0;
      out_req_data    <= '0;
    end else begin
      out_sd_in_valid <= load;
      out_req_done    <= done_nx;
      if (load) begin
        out_sd_addr    <= sel_addr;
        out_sd_data_in <= sel_data;
        out_sd_rw      <= sel_rw;
        out_sd_wmask   <= sel_wmask;
        out_grant      <= win;
      end
      if (fin)
        out_req_data <= in_sd_data_out;
    end
  end

endmodule

// File: tb/tb_sdram_client_arbiter.sv
// Bench for sdram_client_arbiter: directed scenarios plus random traffic
// against a transaction-level model of the arbitration rules.
module tb_sdram_client_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [95:0] r_addr, r_data;
  logic [2:0]  r_rw, r_wm;
  logic [1:0]  va;
  logic [2:0]  vb;
  logic        da, db;
  logic [31:0] sdd;

  logic [1:0]  a_done;
  logic [31:0] a_rdata, a_addr, a_din;
  logic        a_rw, a_wm, a_iv, a_ovr;
  logic [1:0]  a_grant;

  logic [2:0]  b_done;
  logic [31:0] b_rdata, b_addr, b_din;
  logic        b_rw, b_wm, b_iv, b_ovr;
  logic [1:0]  b_grant;

  int nvec = 0;
  int nerr = 0;

  sdram_client_arbiter #(.NUM_CLIENTS(2), .PRIO_CLIENT0(1'b1)) dut_a (
    .clock(clk), .reset(rst),
    .in_req_addr(r_addr[63:0]), .in_req_rw(r_rw[1:0]),
    .in_req_data(r_data[63:0]), .in_req_wmask(r_wm[1:0]),
    .in_req_valid(va), .out_req_done(a_done), .out_req_data(a_rdata),
    .out_sd_addr(a_addr), .out_sd_rw(a_rw), .out_sd_data_in(a_din),
    .out_sd_wmask(a_wm), .out_sd_in_valid(a_iv),
    .in_sd_data_out(sdd), .in_sd_done(da),
    .out_grant(a_grant), .out_overrun(a_ovr)
  );

  sdram_client_arbiter #(.NUM_CLIENTS(3), .PRIO_CLIENT0(1'b0)) dut_b (
    .clock(clk), .reset(rst),
    .in_req_addr(r_addr), .in_req_rw(r_rw),
    .in_req_data(r_data), .in_req_wmask(r_wm),
    .in_req_valid(vb), .out_req_done(b_done), .out_req_data(b_rdata),
    .out_sd_addr(b_addr), .out_sd_rw(b_rw), .out_sd_data_in(b_din),
    .out_sd_wmask(b_wm), .out_sd_in_valid(b_iv),
    .in_sd_data_out(sdd), .in_sd_done(db),
    .out_grant(b_grant), .out_overrun(b_ovr)
  );

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [31:0] ad,
                         input logic [31:0] d, input logic rw,
                         input logic wm);
    r_addr[32*i +: 32] = ad;
    r_data[32*i +: 32] = d;
    r_rw[i] = rw;
    r_wm[i] = wm;
  endtask

  task automatic test_reset();
    do_reset();
    nvec++; if (a_iv !== 1'b0) begin nerr++; $display("FAIL reset_in_valid: got %b want 0", a_iv); end
    nvec++; if (a_rw !== 1'b1) begin nerr++; $display("FAIL reset_sd_rw: got %b want 1", a_rw); end
    nvec++; if (a_done !== 2'b00) begin nerr++; $display("FAIL reset_done: got %b want 00", a_done); end
    nvec++; if (a_grant !== 2'd0) begin nerr++; $display("FAIL reset_grant: got %0d want 0", a_grant); end
    nvec++; if (a_ovr !== 1'b0) begin nerr++; $display("FAIL reset_overrun: got %b want 0", a_ovr); end
    nvec++; if (a_rdata !== 32'h0) begin nerr++; $display("FAIL reset_rdata: got %h want 0", a_rdata); end
    nvec++; if (a_addr !== 32'h0) begin nerr++; $display("FAIL reset_sd_addr: got %h want 0", a_addr); end
    nvec++; if (b_rw !== 1'b1) begin nerr++; $display("FAIL reset_b_sd_rw: got %b want 1", b_rw); end
  endtask

  task automatic test_single_write();
    set_req(1, 32'h40C00005, 32'h7F, 1'b1, 1'b1);
    va = 2'b10;
    @(negedge clk); va = 2'b00;
    nvec++; if (a_iv !== 1'b0) begin nerr++; $display("FAIL wr_early_valid: got %b want 0", a_iv); end
    @(negedge clk);
    nvec++; if (a_iv !== 1'b1) begin nerr++; $display("FAIL wr_in_valid: got %b want 1", a_iv); end
    nvec++; if (a_addr !== 32'h40C00005) begin nerr++; $display("FAIL wr_addr: got %h want 40c00005", a_addr); end
    nvec++; if (a_din !== 32'h7F) begin nerr++; $display("FAIL wr_data: got %h want 7f", a_din); end
    nvec++; if (a_rw !== 1'b1) begin nerr++; $display("FAIL wr_rw: got %b want 1", a_rw); end
    nvec++; if (a_grant !== 2'd1) begin nerr++; $display("FAIL wr_grant: got %0d want 1", a_grant); end
    @(negedge clk);
    nvec++; if (a_iv !== 1'b0) begin nerr++; $display("FAIL wr_valid_pulse: got %b want 0", a_iv); end
    @(negedge clk);
    @(negedge clk);
    nvec++; if (a_done !== 2'b00) begin nerr++; $display("FAIL wr_done_early: got %b want 00", a_done); end
    da = 1'b1; sdd = 32'h0;
    @(negedge clk); da = 1'b0;
    nvec++; if (a_done !== 2'b10) begin nerr++; $display("FAIL wr_done: got %b want 10", a_done); end
    @(negedge clk);
    nvec++; if (a_done !== 2'b00) begin nerr++; $display("FAIL wr_done_pulse: got %b want 00", a_done); end
  endtask

  task automatic test_read_return();
    set_req(0, 32'h82003000, 32'h0, 1'b0, 1'b0);
    va = 2'b01;
    @(negedge clk); va = 2'b00;
    @(negedge clk);
    nvec++; if (a_iv !== 1'b1) begin nerr++; $display("FAIL rd_in_valid: got %b want 1", a_iv); end
    nvec++; if (a_addr !== 32'h82003000) begin nerr++; $display("FAIL rd_addr: got %h want 82003000", a_addr); end
    nvec++; if (a_rw !== 1'b0) begin nerr++; $display("FAIL rd_rw: got %b want 0", a_rw); end
    @(negedge clk);
    da = 1'b1; sdd = 32'hDEADBEEF;
    @(negedge clk); da = 1'b0;
    nvec++; if (a_done !== 2'b01) begin nerr++; $display("FAIL rd_done: got %b want 01", a_done); end
    nvec++; if (a_rdata !== 32'hDEADBEEF) begin nerr++; $display("FAIL rd_data: got %h want deadbeef", a_rdata); end
  endtask

  task automatic test_contention();
    set_req(0, 32'h000000A0, 32'h1, 1'b1, 1'b1);
    set_req(1, 32'h000000A1, 32'h2, 1'b1, 1'b0);
    va = 2'b11;
    @(negedge clk); va = 2'b00;
    @(negedge clk);
    nvec++; if (a_iv !== 1'b1 || a_grant !== 2'd0) begin nerr++; $display("FAIL prio_first: got valid=%b grant=%0d want 1/0", a_iv, a_grant); end
    nvec++; if (a_addr !== 32'hA0) begin nerr++; $display("FAIL prio_first_addr: got %h want a0", a_addr); end
    @(negedge clk);
    da = 1'b1;
    @(negedge clk); da = 1'b0;
    nvec++; if (a_done !== 2'b01 || a_iv !== 1'b0) begin nerr++; $display("FAIL prio_done0: got done=%b valid=%b want 01/0", a_done, a_iv); end
    @(negedge clk);
    nvec++; if (a_iv !== 1'b1 || a_grant !== 2'd1) begin nerr++; $display("FAIL prio_second: got valid=%b grant=%0d want 1/1", a_iv, a_grant); end
    nvec++; if (a_addr !== 32'hA1 || a_wm !== 1'b0) begin nerr++; $display("FAIL prio_second_addr: got %h/%b want a1/0", a_addr, a_wm); end
    @(negedge clk);
    da = 1'b1;
    @(negedge clk); da = 1'b0;
    nvec++; if (a_done !== 2'b10) begin nerr++; $display("FAIL prio_done1: got %b want 10", a_done); end
  endtask

  task automatic test_round_robin();
    int j, g;
    logic [2:0] e;
    for (int i = 0; i < 3; i++) set_req(i, 32'h100 + 32'(i), 32'(i), 1'b0, 1'b0);
    vb = 3'b111;
    @(negedge clk); vb = 3'b000;
    for (int k = 0; k < 6; k++) begin
      g = k % 3;
      e = 3'(1 << g);
      for (j = 0; j < 10 && !b_iv; j++) @(negedge clk);
      nvec++; if (b_iv !== 1'b1) begin nerr++; $display("FAIL rr_issue_%0d: got valid %b want 1", k, b_iv); end
      nvec++; if (b_grant !== 2'(g)) begin nerr++; $display("FAIL rr_grant_%0d: got %0d want %0d", k, b_grant, g); end
      nvec++; if (b_addr !== 32'h100 + 32'(g)) begin nerr++; $display("FAIL rr_addr_%0d: got %h want %h", k, b_addr, 32'h100 + 32'(g)); end
      @(negedge clk);
      db = 1'b1;
      @(negedge clk); db = 1'b0;
      nvec++; if (b_done !== e) begin nerr++; $display("FAIL rr_done_%0d: got %b want %b", k, b_done, e); end
      vb = e;
      @(negedge clk); vb = 3'b000;
    end
  endtask

  task automatic test_back_to_back();
    int niv, nd;
    set_req(1, 32'h11, 32'h5, 1'b1, 1'b1);
    va = 2'b10;
    @(negedge clk); va = 2'b00;
    @(negedge clk);
    @(negedge clk);
    set_req(1, 32'h22, 32'h6, 1'b0, 1'b0);
    va = 2'b10; da = 1'b1; sdd = 32'hAB;
    @(negedge clk); va = 2'b00; da = 1'b0;
    nvec++; if (a_done !== 2'b10 || a_ovr !== 1'b0) begin nerr++; $display("FAIL b2b_done: got done=%b ovr=%b want 10/0", a_done, a_ovr); end
    @(negedge clk);
    nvec++; if (a_iv !== 1'b1 || a_addr !== 32'h22) begin nerr++; $display("FAIL b2b_reissue: got valid=%b addr=%h want 1/22", a_iv, a_addr); end
    @(negedge clk);
    da = 1'b1;
    @(negedge clk); da = 1'b0;
    nvec++; if (a_done !== 2'b10 || a_ovr !== 1'b0) begin nerr++; $display("FAIL b2b_done2: got done=%b ovr=%b want 10/0", a_done, a_ovr); end
    set_req(1, 32'h33, 32'h7, 1'b1, 1'b1);
    va = 2'b10;
    @(negedge clk); va = 2'b00;
    @(negedge clk);
    set_req(1, 32'h44, 32'h8, 1'b1, 1'b1);
    va = 2'b10;
    @(negedge clk); va = 2'b00;
    nvec++; if (a_ovr !== 1'b1) begin nerr++; $display("FAIL ovr_flag: got %b want 1", a_ovr); end
    da = 1'b1;
    @(negedge clk); da = 1'b0;
    nvec++; if (a_done !== 2'b10) begin nerr++; $display("FAIL ovr_first_done: got %b want 10", a_done); end
    niv = 0; nd = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      niv += int'(a_iv);
      nd += int'(a_done != 2'b00);
    end
    nvec++; if (niv != 0) begin nerr++; $display("FAIL ovr_no_reissue: got %0d issues want 0", niv); end
    nvec++; if (nd != 0) begin nerr++; $display("FAIL ovr_single_done: got %0d extra dones want 0", nd); end
  endtask

  task automatic test_reset_mid_wait();
    int niv, nd;
    set_req(0, 32'h55, 32'h9, 1'b0, 1'b0);
    va = 2'b01;
    @(negedge clk); va = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    da = 1'b1; sdd = 32'h99;
    @(negedge clk); da = 1'b0;
    nvec++; if (a_done !== 2'b00) begin nerr++; $display("FAIL rst_stray_done: got %b want 00", a_done); end
    nvec++; if (a_iv !== 1'b0 || a_rw !== 1'b1) begin nerr++; $display("FAIL rst_sd_port: got valid=%b rw=%b want 0/1", a_iv, a_rw); end
    nvec++; if (a_ovr !== 1'b0 || a_rdata !== 32'h0) begin nerr++; $display("FAIL rst_state: got ovr=%b rdata=%h want 0/0", a_ovr, a_rdata); end
    niv = 0; nd = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      niv += int'(a_iv);
      nd += int'(a_done != 2'b00);
    end
    nvec++; if (niv != 0 || nd != 0) begin nerr++; $display("FAIL rst_pend_empty: got %0d issues %0d dones want 0/0", niv, nd); end
  endtask

  task automatic test_spurious_done();
    da = 1'b1; sdd = 32'h12345678;
    @(negedge clk); da = 1'b0;
    nvec++; if (a_rdata !== 32'h0 || a_done !== 2'b00) begin nerr++; $display("FAIL spur_done: got rdata=%h done=%b want 0/00", a_rdata, a_done); end
    nvec++; if (a_iv !== 1'b0 || a_rw !== 1'b1 || a_addr !== 32'h0 || a_grant !== 2'd0) begin
      nerr++; $display("FAIL spur_port: got valid=%b rw=%b addr=%h grant=%0d want 0/1/0/0", a_iv, a_rw, a_addr, a_grant);
    end
  endtask

  task automatic test_random(input int which, input int ncyc);
    int n, mrr, mg, cnt, w, idx;
    bit prio, midle, pdone, ddone, exp_iv;
    bit mp[3];
    logic [31:0] ma[3], md[3], na[3], nd[3];
    logic mrw[3], mwm[3], nrw[3], nwm[3];
    logic [2:0] pv, nv, exp_done, o_done;
    logic [31:0] pdata, m_rdata, o_addr, o_din, o_rdata;
    logic o_iv, o_rw, o_wm, o_ovr;
    logic [1:0] o_grant;
    n = which ? 3 : 2;
    prio = (which == 0);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      mp[i] = 0; ma[i] = '0; md[i] = '0; mrw[i] = 0; mwm[i] = 0;
      na[i] = '0; nd[i] = '0; nrw[i] = 0; nwm[i] = 0;
    end
    mrr = 0; mg = 0; cnt = 0; midle = 1; pdone = 0;
    pv = '0; pdata = '0; m_rdata = '0;
    for (int c = 0; c < ncyc; c++) begin
      exp_done = '0;
      exp_iv = 0;
      if (pdone) begin
        exp_done[mg] = 1'b1;
        m_rdata = pdata;
        mp[mg] = 0;
        mrr = (mg + 1) % n;
        midle = 1;
      end else if (midle) begin
        w = -1;
        if (prio && mp[0]) w = 0;
        else begin
          for (int k = 0; k < n; k++) begin
            idx = (mrr + k) % n;
            if (w < 0 && mp[idx] && !(prio && idx == 0)) w = idx;
          end
        end
        if (w >= 0) begin exp_iv = 1; mg = w; midle = 0; end
      end
      for (int i = 0; i < n; i++) begin
        if (pv[i]) begin
          mp[i] = 1; ma[i] = na[i]; md[i] = nd[i]; mrw[i] = nrw[i]; mwm[i] = nwm[i];
        end
      end
      o_iv    = which ? b_iv : a_iv;
      o_addr  = which ? b_addr : a_addr;
      o_din   = which ? b_din : a_din;
      o_rw    = which ? b_rw : a_rw;
      o_wm    = which ? b_wm : a_wm;
      o_grant = which ? b_grant : a_grant;
      o_done  = which ? b_done : {1'b0, a_done};
      o_rdata = which ? b_rdata : a_rdata;
      o_ovr   = which ? b_ovr : a_ovr;
      nvec++; if (o_iv !== exp_iv) begin nerr++; $display("FAIL rnd%0d_valid c=%0d: got %b want %b", which, c, o_iv, exp_iv); end
      if (exp_iv) begin
        nvec++; if (o_grant !== 2'(mg)) begin nerr++; $display("FAIL rnd%0d_grant c=%0d: got %0d want %0d", which, c, o_grant, mg); end
        nvec++; if (o_addr !== ma[mg] || o_din !== md[mg]) begin nerr++; $display("FAIL rnd%0d_payload c=%0d: got %h/%h want %h/%h", which, c, o_addr, o_din, ma[mg], md[mg]); end
        nvec++; if (o_rw !== mrw[mg] || o_wm !== mwm[mg]) begin nerr++; $display("FAIL rnd%0d_rw_wm c=%0d: got %b/%b want %b/%b", which, c, o_rw, o_wm, mrw[mg], mwm[mg]); end
      end
      nvec++; if (o_done !== exp_done) begin nerr++; $display("FAIL rnd%0d_done c=%0d: got %b want %b", which, c, o_done, exp_done); end
      nvec++; if (o_rdata !== m_rdata) begin nerr++; $display("FAIL rnd%0d_rdata c=%0d: got %h want %h", which, c, o_rdata, m_rdata); end
      nvec++; if (o_ovr !== 1'b0) begin nerr++; $display("FAIL rnd%0d_overrun c=%0d: got %b want 0", which, c, o_ovr); end
      ddone = 0;
      if (cnt > 0) begin cnt--; if (cnt == 0) ddone = 1; end
      if (exp_iv) cnt = int'($urandom_range(1, 4));
      nv = '0;
      for (int i = 0; i < n; i++) begin
        if ((!mp[i] || (ddone && mg == i)) && $urandom_range(0, 2) == 0) begin
          nv[i] = 1'b1;
          na[i] = $urandom; nd[i] = $urandom;
          nrw[i] = 1'($urandom_range(0, 1)); nwm[i] = 1'($urandom_range(0, 1));
          set_req(i, na[i], nd[i], nrw[i], nwm[i]);
        end
      end
      if (which != 0) begin vb = nv; db = ddone; end
      else begin va = nv[1:0]; da = ddone; end
      pdata = $urandom;
      sdd = pdata;
      pv = nv;
      pdone = ddone;
      @(negedge clk);
    end
    va = '0; vb = '0; da = 1'b0; db = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    va = '0; vb = '0; da = 1'b0; db = 1'b0; sdd = '0;
    r_addr = '0; r_data = '0; r_rw = '0; r_wm = '0;
    test_reset();
    test_single_write();
    test_read_return();
    test_contention();
    test_round_robin();
    test_back_to_back();
    test_reset_mid_wait();
    test_spurious_done();
    test_random(0, 600);
    test_random(1, 600);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
